// File: rtl/shazam_pkg.sv
// rtl/shazam_pkg.sv - shared constants and state type for the peak path
package shazam_pkg;

    localparam int          NUM_PEAKS   = 16;
    localparam int          PEAK_W      = 25;
    localparam logic [7:0]  SYNC_BYTE   = 8'hA5;
    localparam int          FRAME_BYTES = 3 + 4 * NUM_PEAKS;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        SEQ,
        PEAK,
        CSUM
    } tx_state_t;

endpackage

// File: rtl/peak_frame_tx_if.sv
// rtl/peak_frame_tx_if.sv - byte stream toward the host link bridge
interface peak_frame_tx_if;

    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_last;

    modport master (
        output tx_data,
        output tx_valid,
        output tx_last,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        input  tx_last,
        output tx_ready
    );

endinterface

// File: rtl/peak_frame_tx_byte_select.sv
// rtl/peak_frame_tx_byte_select.sv - picks one MSB-first byte of one buffered peak
module peak_byte_select #(
    parameter int NUM_PEAKS = 16,
    parameter int PEAK_W    = 25,
    parameter int PIDX_W    = 4
) (
    input  logic [NUM_PEAKS-1:0][PEAK_W-1:0] peaks_i,
    input  logic [PIDX_W-1:0]                peak_idx_i,
    input  logic [1:0]                       byte_idx_i,
    output logic [7:0]                       byte_o
);

    logic [31:0] word;

    // Peaks are zero-extended to a 32-bit word so byte 0 carries only the top index bit.
    always_comb begin
        word = 32'(peaks_i[peak_idx_i]);
        case (byte_idx_i)
            2'd0:    byte_o = word[31:24];
            2'd1:    byte_o = word[23:16];
            2'd2:    byte_o = word[15:8];
            default: byte_o = word[7:0];
        endcase
    end

endmodule

// File: rtl/peak_frame_tx.sv
// rtl/peak_frame_tx.sv - captures a peak array and sends it as a framed, checksummed byte stream
module peak_frame_tx #(
    parameter int         NUM_PEAKS = shazam_pkg::NUM_PEAKS,
    parameter int         PEAK_W    = shazam_pkg::PEAK_W,
    parameter logic [7:0] SYNC_BYTE = shazam_pkg::SYNC_BYTE
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_PEAKS-1:0][PEAK_W-1:0] maximas,
    input  logic                             maximas_found_active,
    peak_frame_tx_if.master                  tx,
    output logic                             busy,
    output logic [7:0]                       dropped_frames
);

    import shazam_pkg::*;

    localparam int                PIDX_W    = (NUM_PEAKS > 1) ? $clog2(NUM_PEAKS) : 1;
    localparam logic [PIDX_W-1:0] LAST_PEAK = PIDX_W'(NUM_PEAKS - 1);

    tx_state_t                        state_q, state_d;
    logic [PIDX_W-1:0]                peak_cnt_q, peak_cnt_d;
    logic [1:0]                       byte_cnt_q, byte_cnt_d;
    logic [7:0]                       seq_q, seq_d;
    logic [7:0]                       csum_q, csum_d;
    logic [7:0]                       drop_q, drop_d;
    logic [7:0]                       data_q, data_d;
    logic                             valid_q, valid_d;
    logic                             last_q, last_d;
    logic                             busy_q, busy_d;
    logic [NUM_PEAKS-1:0][PEAK_W-1:0] buf_q;
    logic                             hs;
    logic                             capture;
    logic [7:0]                       sel_byte;

    peak_byte_select #(
        .NUM_PEAKS (NUM_PEAKS),
        .PEAK_W    (PEAK_W),
        .PIDX_W    (PIDX_W)
    ) u_sel (
        .peaks_i    (buf_q),
        .peak_idx_i (peak_cnt_d),
        .byte_idx_i (byte_cnt_d),
        .byte_o     (sel_byte)
    );

    always_comb begin
        hs         = valid_q && tx.tx_ready;
        capture    = 1'b0;
        state_d    = state_q;
        peak_cnt_d = peak_cnt_q;
        byte_cnt_d = byte_cnt_q;
        seq_d      = seq_q;
        csum_d     = csum_q;
        drop_d     = drop_q;

        case (state_q)
            IDLE: capture = maximas_found_active;
            SYNC: if (hs) state_d = SEQ;
            SEQ: if (hs) begin
                state_d    = PEAK;
                csum_d     = csum_q + data_q;
                peak_cnt_d = '0;
                byte_cnt_d = 2'd0;
            end
            PEAK: if (hs) begin
                csum_d = csum_q + data_q;
                if (byte_cnt_q == 2'd3) begin
                    byte_cnt_d = 2'd0;
                    if (peak_cnt_q == LAST_PEAK) state_d = CSUM;
                    else                         peak_cnt_d = peak_cnt_q + 1'b1;
                end else begin
                    byte_cnt_d = byte_cnt_q + 2'd1;
                end
            end
            CSUM: if (hs) begin
                seq_d   = seq_q + 8'd1;
                state_d = IDLE;
                capture = maximas_found_active;
            end
            default: state_d = IDLE;
        endcase

        if (capture) begin
            state_d = SYNC;
            csum_d  = 8'd0;
        end else if (maximas_found_active && drop_q != 8'hFF) begin
            drop_d = drop_q + 8'd1;
        end

        // Outputs are precomputed for the next state so they leave the flops directly.
        case (state_d)
            SYNC:    data_d = SYNC_BYTE;
            SEQ:     data_d = seq_q;
            PEAK:    data_d = sel_byte;
            CSUM:    data_d = csum_d;
            default: data_d = 8'd0;
        endcase
        valid_d = (state_d != IDLE);
        last_d  = (state_d == CSUM);
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            peak_cnt_q <= '0;
            byte_cnt_q <= 2'd0;
            seq_q      <= 8'd0;
            csum_q     <= 8'd0;
            drop_q     <= 8'd0;
            data_q     <= 8'd0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            peak_cnt_q <= peak_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            seq_q      <= seq_d;
            csum_q     <= csum_d;
            drop_q     <= drop_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            last_q     <= last_d;
            busy_q     <= busy_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset && capture) buf_q <= maximas;
    end

    assign tx.tx_data     = data_q;
    assign tx.tx_valid    = valid_q;
    assign tx.tx_last     = last_q;
    assign busy           = busy_q;
    assign dropped_frames = drop_q;

endmodule

// File: tb/tb_peak_frame_tx.sv
// tb/tb_peak_frame_tx.sv - directed vector and sequence bench for peak_frame_tx
module tb_peak_frame_tx;

    import shazam_pkg::*;

    typedef logic [NUM_PEAKS-1:0][PEAK_W-1:0] pk_t;

    typedef struct {
        int         off;
        logic [7:0] data;
        logic       last;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       strobe;
    pk_t        maximas;
    logic       busy;
    logic [7:0] dropped;

    peak_frame_tx_if tx_if ();

    peak_frame_tx dut (
        .clk                  (clk),
        .reset                (reset),
        .maximas              (maximas),
        .maximas_found_active (strobe),
        .tx                   (tx_if),
        .busy                 (busy),
        .dropped_frames       (dropped)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_fail = 0;
    logic [7:0] got [FRAME_BYTES];
    logic       got_last [FRAME_BYTES];
    logic [7:0] exp_f [FRAME_BYTES];
    int         n_got, cyc, lasts, viol;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic build(input pk_t p, input logic [7:0] seq);
        logic [7:0]  s;
        logic [31:0] w;
        exp_f[0] = SYNC_BYTE;
        exp_f[1] = seq;
        s = seq;
        for (int i = 0; i < NUM_PEAKS; i++) begin
            w = 32'(p[i]);
            for (int b = 0; b < 4; b++) begin
                exp_f[2 + 4 * i + b] = w[31 - 8 * b -: 8];
                s = s + w[31 - 8 * b -: 8];
            end
        end
        exp_f[FRAME_BYTES - 1] = s;
    endtask

    task automatic start_frame(input pk_t p);
        maximas = p;
        strobe  = 1'b1;
        @(posedge clk); #1;
        strobe  = 1'b0;
    endtask

    // Records handshaken bytes; optionally pulses a strobe with alt peaks alongside byte strobe_at.
    task automatic collect(input bit rnd, input int strobe_at, input pk_t alt);
        logic       pv, pr, pl;
        logic [7:0] pd;
        n_got = 0; cyc = 0; lasts = 0; viol = 0;
        pv = 1'b0; pr = 1'b1; pd = 8'd0; pl = 1'b0;
        while (n_got < FRAME_BYTES && cyc < 4000) begin
            if (pv && !pr && (tx_if.tx_valid !== 1'b1 || tx_if.tx_data !== pd || tx_if.tx_last !== pl))
                viol++;
            if (n_got > 0 && tx_if.tx_valid !== 1'b1) viol++;
            tx_if.tx_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (tx_if.tx_valid && tx_if.tx_ready) begin
                got[n_got]      = tx_if.tx_data;
                got_last[n_got] = tx_if.tx_last;
                if (tx_if.tx_last) lasts++;
                if (n_got == strobe_at) begin
                    maximas = alt;
                    strobe  = 1'b1;
                end
                n_got++;
            end
            pv = tx_if.tx_valid; pr = tx_if.tx_ready; pd = tx_if.tx_data; pl = tx_if.tx_last;
            @(posedge clk); #1;
            strobe = 1'b0;
            cyc++;
        end
        tx_if.tx_ready = 1'b1;
    endtask

    task automatic check_frame(input string name, input pk_t p, input logic [7:0] seq);
        int bad;
        bad = 0;
        build(p, seq);
        for (int i = 0; i < FRAME_BYTES; i++)
            if (got[i] !== exp_f[i]) bad++;
        check({name, "_len"}, n_got, FRAME_BYTES);
        check({name, "_bad_bytes"}, bad, 0);
        check({name, "_seq"}, got[1], seq);
        check({name, "_csum"}, got[FRAME_BYTES - 1], exp_f[FRAME_BYTES - 1]);
        check({name, "_last_count"}, lasts, 1);
        check({name, "_last_on_csum"}, got_last[FRAME_BYTES - 1], 1'b1);
        check({name, "_stream_viol"}, viol, 0);
    endtask

    initial begin
        vec_t vecs [10];
        pk_t  pa, pb, pr_;

        vecs[0] = '{0,  8'hA5, 1'b0};
        vecs[1] = '{1,  8'h00, 1'b0};
        vecs[2] = '{21, 8'h00, 1'b0};
        vecs[3] = '{22, 8'h01, 1'b0};
        vecs[4] = '{23, 8'hFF, 1'b0};
        vecs[5] = '{24, 8'hFF, 1'b0};
        vecs[6] = '{25, 8'hFF, 1'b0};
        vecs[7] = '{26, 8'h00, 1'b0};
        vecs[8] = '{65, 8'h00, 1'b0};
        vecs[9] = '{66, 8'hFE, 1'b1};

        pa = '0;
        pa[5] = 25'h1FFFFFF;
        for (int i = 0; i < NUM_PEAKS; i++) pb[i] = PEAK_W'({i[8:0], 16'h1234 + 16'(i * 16'h0101)});

        reset = 1'b0; strobe = 1'b0; maximas = '0; tx_if.tx_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", tx_if.tx_valid, 1'b0);
        check("rst_last", tx_if.tx_last, 1'b0);
        check("rst_data", tx_if.tx_data, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_dropped", dropped, 8'h00);
        reset = 1'b1;
        @(posedge clk); #1;

        // Single frame, hand-computed byte positions
        start_frame(pa);
        check("start_valid", tx_if.tx_valid, 1'b1);
        check("start_sync", tx_if.tx_data, 8'hA5);
        check("start_busy", busy, 1'b1);
        collect(1'b0, -1, '0);
        for (int v = 0; v < 10; v++) begin
            check($sformatf("single_b%0d_data", vecs[v].off), got[vecs[v].off], vecs[v].data);
            check($sformatf("single_b%0d_last", vecs[v].off), got_last[vecs[v].off], vecs[v].last);
        end
        check("single_cycles", cyc, FRAME_BYTES);
        check_frame("single", pa, 8'd0);
        check("single_idle_busy", busy, 1'b0);
        check("single_idle_valid", tx_if.tx_valid, 1'b0);

        // Backpressure
        start_frame(pa);
        collect(1'b1, -1, '0);
        check_frame("bp", pa, 8'd1);

        // Strobe dropped at byte 10
        start_frame(pb);
        collect(1'b0, 10, pa);
        check_frame("drop", pb, 8'd2);
        check("drop_count", dropped, 8'd1);

        // Saturation of the drop counter while stalled on SYNC
        start_frame(pb);
        tx_if.tx_ready = 1'b0;
        maximas = pa;
        strobe = 1'b1;
        repeat (300) begin
            @(posedge clk); #1;
        end
        strobe = 1'b0;
        check("sat_count", dropped, 8'd255);
        check("sat_stall_data", tx_if.tx_data, 8'hA5);
        check("sat_stall_valid", tx_if.tx_valid, 1'b1);
        collect(1'b0, -1, '0);
        check_frame("sat", pb, 8'd3);

        // Back-to-back: strobe coincident with CSUM handshake
        start_frame(pa);
        collect(1'b0, FRAME_BYTES - 1, pb);
        check_frame("b2b_first", pa, 8'd4);
        check("b2b_valid", tx_if.tx_valid, 1'b1);
        check("b2b_sync", tx_if.tx_data, 8'hA5);
        check("b2b_busy", busy, 1'b1);
        collect(1'b0, -1, '0);
        check_frame("b2b_second", pb, 8'd5);
        check("b2b_dropped", dropped, 8'd255);

        // Reset mid-frame
        start_frame(pb);
        repeat (30) begin
            @(posedge clk); #1;
        end
        check("mid_valid_before", tx_if.tx_valid, 1'b1);
        reset = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_valid", tx_if.tx_valid, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_data", tx_if.tx_data, 8'h00);
        check("mid_rst_last", tx_if.tx_last, 1'b0);
        check("mid_rst_dropped", dropped, 8'h00);
        reset = 1'b1;
        @(posedge clk); #1;
        check("mid_idle_valid", tx_if.tx_valid, 1'b0);

        // SEQ wrap over 257 frames with varied peaks
        for (int f = 0; f < 257; f++) begin
            for (int i = 0; i < NUM_PEAKS; i++) pr_[i] = PEAK_W'($urandom);
            start_frame(pr_);
            collect(f[0], -1, '0);
            check_frame($sformatf("wrap%0d", f), pr_, f[7:0]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/peak_frame_tx.md
# peak_frame_tx

Transmit side of the peak path: captures the 16-entry peak array from `shazam_core` on its completion strobe and serializes it as a framed byte stream over a valid/ready interface toward the host link (UART/USB bridge). It sits directly after `find_maximas` and decouples peak production from the slower link. Frames carry a sync byte, a sequence number, the packed peaks and an additive checksum.

## Interface
- `NUM_PEAKS`, default 16: peaks per frame.
- `PEAK_W`, default 25: peak width, `{index[8:0], magnitude[15:0]}`.
- `SYNC_BYTE`, default 8'hA5: first byte of every frame.
- `clk`  input  1  single clock.
- `reset`  input  1  synchronous, active-low reset (0 = reset).
- `maximas`  input  NUM_PEAKS x PEAK_W  peak array, valid in the strobe cycle.
- `maximas_found_active`  input  1  one-cycle strobe: new peak array present.
- `tx_data`  output  8  stream byte.
- `tx_valid`  output  1  `tx_data` valid.
- `tx_ready`  input  1  sink accepts the byte when high together with `tx_valid`.
- `tx_last`  output  1  high with the checksum byte.
- `busy`  output  1  frame capture held, transmission in progress.
- `dropped_frames`  output  8  strobes lost while busy, saturating.

## Operation
- Frame = SYNC, SEQ, then per peak 4 bytes MSB-first: `{7'b0, p[24]}`, `p[23:16]`, `p[15:8]`, `p[7:0]`, then CSUM. Length 3 + 4*NUM_PEAKS bytes (67 at default).
- CSUM = sum mod 256 of SEQ and all peak bytes; SYNC excluded.
- States: IDLE -> SYNC -> SEQ -> PEAK -> CSUM -> IDLE.
- State advance only on handshake (`tx_valid && tx_ready`). PEAK uses a 2-bit byte counter and a peak counter; it leaves after byte 3 of peak NUM_PEAKS-1.
- Capture: in IDLE, a strobe copies `maximas` into the frame buffer and enters SYNC.
- Strobe during SYNC/SEQ/PEAK, or during CSUM without the final handshake: dropped, `dropped_frames` +1, saturating at 255; the buffer is unchanged.
- Strobe in the same cycle as the CSUM handshake: captured; next state is SYNC, with no IDLE cycle.
- SEQ starts at 0 and increments mod 256 on each CSUM handshake (255 -> 0).
- Reset, including mid-frame, clears the frame: state IDLE, `tx_valid`/`tx_last`/`busy` = 0, `tx_data` = 0, SEQ = 0, `dropped_frames` = 0, checksum accumulator = 0. A partial frame is abandoned, not completed.

## Timing
- Strobe at cycle N in IDLE -> `tx_valid`=1 with `tx_data`=SYNC_BYTE at N+1.
- With `tx_ready` held high, one byte per cycle; the frame occupies 67 consecutive cycles.
- While `tx_valid && !tx_ready`, `tx_data` and `tx_last` are held stable.
- `tx_valid` never deasserts mid-frame.
- `busy` = (state != IDLE), registered.
- `tx_data`, `tx_valid` and `tx_last` are registered outputs; no combinational path from `tx_ready` to outputs except through state.
- Checksum is accumulated on each handshake of SEQ/PEAK bytes; CSUM byte is available the cycle after the last peak byte handshake.

## Structure
- `shazam_pkg`: `NUM_PEAKS`, `PEAK_W`, `SYNC_BYTE`, `FRAME_BYTES`, and the `tx_state_t` enum (IDLE, SYNC, SEQ, PEAK, CSUM). It is shared with `find_maximas` and future host-side decode logic.
- Sub-module `peak_byte_select`: combinational selection of the byte for a given (peak counter, byte counter) from the buffered array. Keeps the FSM file small.
- Frame buffer: NUM_PEAKS x PEAK_W register array, written only on capture.

## Test plan
- Single frame: peak 5 = 25'h1FFFFFF, others 0, `tx_ready`=1 -> bytes A5 00, 20x 00, 01 FF FF FF, 40x 00, FE. `tx_last` only on FE; 67 bytes.
- Backpressure: toggle `tx_ready` pseudo-randomly -> identical byte sequence, data stable during stalls, no `tx_valid` gaps.
- Drop: second strobe at byte 10 -> `dropped_frames`=1, first frame content unchanged. 300 strobes while busy -> saturates at 255.
- Back-to-back: strobe coincident with CSUM handshake -> next cycle SYNC with SEQ=01; new peaks are transmitted.
- Reset mid-frame: assert `reset`=0 at byte 30 -> next cycle `tx_valid`=0, `busy`=0. New frame starts with SEQ=00.
- SEQ wrap: 257 frames -> SEQ values 00..FF then 00. Each checksum is correct.
